// File: rtl/mpu_operand_loader.sv
// mpu_operand_loader: gathers 25 A then 25 B signed elements from a byte stream and
// holds them as flattened 5x5 operand buses until the ALU side accepts the pair.
module mpu_operand_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [ELEM_W*DIM*DIM-1:0] matrix_a,
    output logic [ELEM_W*DIM*DIM-1:0] matrix_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err
);
    localparam int N = DIM * DIM;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t              state_q;
    logic [4:0]          idx_q;
    logic [4:0]          idx_d;
    logic [ELEM_W*N-1:0] a_q;
    logic [ELEM_W*N-1:0] b_q;
    logic                err_q;
    logic                accept;
    logic                frame_err;

    assign in_ready  = !rst && state_q != HOLD;
    assign accept    = in_valid && in_ready;
    // in_last must coincide exactly with the final B element
    assign frame_err = accept && (in_last != (state_q == LOAD_B && idx_q == LAST));
    assign idx_d     = idx_q == LAST ? 5'd0 : idx_q + 5'd1;
    assign matrix_a  = a_q;
    assign matrix_b  = b_q;
    assign out_valid = state_q == HOLD;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= frame_err;
            if (frame_err) begin
                state_q <= LOAD_A;
                idx_q   <= '0;
                a_q     <= '0;
                b_q     <= '0;
            end else begin
                case (state_q)
                    LOAD_A: if (accept) begin
                        a_q[idx_q*ELEM_W +: ELEM_W] <= in_data;
                        idx_q <= idx_d;
                        if (idx_q == LAST) state_q <= LOAD_B;
                    end
                    LOAD_B: if (accept) begin
                        b_q[idx_q*ELEM_W +: ELEM_W] <= in_data;
                        idx_q <= idx_d;
                        if (idx_q == LAST) state_q <= HOLD;
                    end
                    HOLD:    if (out_ready) state_q <= LOAD_A;
                    default: state_q <= LOAD_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mpu_operand_loader.sv
// tb_mpu_operand_loader: randomized scenarios checked against an element-count reference model.
module tb_mpu_operand_loader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         err;

    int n_checks = 0;
    int n_fail = 0;

    // Model: position within the 50-element pair, stored operands, hold and error flags
    logic [7:0] m_a [25];
    logic [7:0] m_b [25];
    int         m_cnt = 0;
    logic       m_hold = 1'b0;
    logic       m_err = 1'b0;

    mpu_operand_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [199:0] pack(input logic [7:0] m [25]);
        logic [199:0] r = '0;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = m[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 25; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_cnt = 0;
    endtask

    task automatic model_push(input logic [7:0] d, input logic l);
        m_err = 1'b0;
        if (l != (m_cnt == 49)) begin
            model_clear();
            m_err = 1'b1;
        end else begin
            if (m_cnt < 25) m_a[m_cnt] = d;
            else m_b[m_cnt-25] = d;
            m_cnt++;
            if (m_cnt == 50) begin
                m_cnt = 0;
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        model_push(d, l);
    endtask

    task automatic idle(input int n, input logic ordy);
        out_ready = ordy;
        repeat (n) begin
            @(negedge clk);
            m_err = 1'b0;
            if (m_hold && out_ready) m_hold = 1'b0;
        end
        out_ready = 1'b0;
    endtask

    task automatic push_random(input int n, input int last_at);
        for (int k = 0; k < n; k++) push(8'($urandom), k == last_at);
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (matrix_a !== '0 || matrix_b !== '0) begin n_fail++; $display("FAIL reset_matrices: a=%h b=%h want 0", matrix_a, matrix_b); end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_nominal();
        for (int k = 0; k < 49; k++) push(k < 25 ? 8'(k + 1) : 8'(50 - k), 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_early_valid: got %b want 0", out_valid); end
        push(8'd1, 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nominal_valid: got %b want 1", out_valid); end
        n_checks++; if (matrix_a[7:0] !== 8'd1 || matrix_a[199:192] !== 8'd25) begin n_fail++; $display("FAIL nominal_a_ends: got %0d,%0d want 1,25", matrix_a[7:0], matrix_a[199:192]); end
        n_checks++; if (matrix_b[7:0] !== 8'd25) begin n_fail++; $display("FAIL nominal_b0: got %0d want 25", matrix_b[7:0]); end
        n_checks++; if ($signed(matrix_a[7:0]) - $signed(matrix_b[7:0]) !== -24) begin n_fail++; $display("FAIL nominal_sub00: got %0d want -24", $signed(matrix_a[7:0]) - $signed(matrix_b[7:0])); end
        n_checks++; if (matrix_a !== pack(m_a) || matrix_b !== pack(m_b)) begin n_fail++; $display("FAIL nominal_buses: a=%h b=%h want a=%h b=%h", matrix_a, matrix_b, pack(m_a), pack(m_b)); end
    endtask

    task automatic test_backpressure();
        logic [199:0] a_snap;
        logic [199:0] b_snap;
        a_snap = pack(m_a);
        b_snap = pack(m_b);
        in_valid = 1'b1;
        in_data = 8'h5A;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_handshake c%0d: in_ready=%b out_valid=%b want 0,1", c, in_ready, out_valid); end
            n_checks++; if (matrix_a !== a_snap || matrix_b !== b_snap) begin n_fail++; $display("FAIL hold_stable c%0d: a=%h b=%h", c, matrix_a, matrix_b); end
        end
        in_valid = 1'b0;
        idle(1, 1'b1);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL release_hold: in_ready=%b out_valid=%b want 1,0", in_ready, out_valid); end
        n_checks++; if (matrix_a !== a_snap || matrix_b !== b_snap) begin n_fail++; $display("FAIL kept_after_accept: a=%h b=%h", matrix_a, matrix_b); end
        idle(2, 1'b1);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL out_ready_ignored: in_ready=%b out_valid=%b want 1,0", in_ready, out_valid); end
    endtask

    task automatic test_signed();
        push(8'h80, 1'b0);
        push(8'h7F, 1'b0);
        push(8'hFF, 1'b0);
        for (int k = 3; k < 50; k++) push(8'($urandom), k == 49);
        n_checks++; if (matrix_a[23:0] !== 24'hFF7F80) begin n_fail++; $display("FAIL signed_slots: got %h want ff7f80", matrix_a[23:0]); end
        n_checks++; if ($signed(matrix_a[7:0]) !== -128 || $signed(matrix_a[23:16]) !== -1) begin n_fail++; $display("FAIL signed_values: got %0d,%0d want -128,-1", $signed(matrix_a[7:0]), $signed(matrix_a[23:16])); end
        idle(1, 1'b1);
    endtask

    task automatic test_early_last();
        push_random(29, -1);
        push(8'h33, 1'b1);
        n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL early_err: err=%b out_valid=%b want 1,0", err, out_valid); end
        n_checks++; if (matrix_a !== '0 || matrix_b !== '0) begin n_fail++; $display("FAIL early_cleared: a=%h b=%h want 0", matrix_a, matrix_b); end
        idle(1, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL early_err_width: got %b want 0", err); end
        push_random(50, 49);
        n_checks++; if (out_valid !== 1'b1 || matrix_a !== pack(m_a) || matrix_b !== pack(m_b)) begin n_fail++; $display("FAIL early_recover: out_valid=%b a=%h b=%h", out_valid, matrix_a, matrix_b); end
        idle(1, 1'b1);
    endtask

    task automatic test_missing_last();
        push_random(50, -1);
        n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL missing_err: err=%b out_valid=%b want 1,0", err, out_valid); end
        n_checks++; if (matrix_a !== '0 || matrix_b !== '0) begin n_fail++; $display("FAIL missing_cleared: a=%h b=%h want 0", matrix_a, matrix_b); end
        idle(1, 1'b0);
        n_checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL missing_after: err=%b out_valid=%b want 0,0", err, out_valid); end
    endtask

    task automatic test_reset_mid_load();
        push_random(37, -1);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (matrix_a !== '0 || matrix_b !== '0) begin n_fail++; $display("FAIL async_reset_mats: a=%h b=%h want 0", matrix_a, matrix_b); end
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctrl: in_ready=%b out_valid=%b err=%b want 0", in_ready, out_valid, err); end
        model_clear();
        m_hold = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_random(50, 49);
        n_checks++; if (out_valid !== 1'b1 || matrix_a !== pack(m_a) || matrix_b !== pack(m_b)) begin n_fail++; $display("FAIL reset_reload: out_valid=%b a=%h b=%h", out_valid, matrix_a, matrix_b); end
        idle(1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 50; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom));
                push(8'($urandom), (k == 49) ^ ($urandom_range(0, 79) == 0));
                if (m_err) break;
            end
            n_checks++; if (out_valid !== m_hold || err !== m_err) begin n_fail++; $display("FAIL pair%0d_flags: out_valid=%b err=%b want %b,%b", p, out_valid, err, m_hold, m_err); end
            n_checks++; if (matrix_a !== pack(m_a) || matrix_b !== pack(m_b)) begin n_fail++; $display("FAIL pair%0d_buses: a=%h b=%h want a=%h b=%h", p, matrix_a, matrix_b, pack(m_a), pack(m_b)); end
            idle($urandom_range(0, 3), 1'b0);
            if (m_hold) idle(1, 1'b1);
            if (m_cnt != 0) begin
                model_clear();
                m_hold = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_signed();
        test_early_last();
        test_missing_last();
        test_reset_mid_load();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
